// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file (NUM_RD read ports, NUM_WR write ports).
// Reads are registered with one cycle of latency and a per-port valid flag.
// Entry 0 can be hardwired to zero (ZERO_REG). Among write ports aimed at the same
// address, the highest port index wins.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to reads
// (write-first). Without it, a same-cycle read returns the old contents (read-first).
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int INIT_IDX = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage array and the registered read stage.
  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data_p1;
  logic [NUM_RD-1:0]        r_vld_p1;

  // Combinational read value, before it is captured into the output register.
  logic [NUM_RD*DATA_W-1:0] w_rd_data_p0;

  // Reset contents of entry idx. Entry 0 is zero either way, which also
  // covers ZERO_REG=1.
  function automatic logic [DATA_W-1:0] init_val(input int idx);
    if (INIT_IDX != 0) return DATA_W'(idx);
    return '0;
  endfunction

  // True when a write to this address must be dropped because of the zero register.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Write ports: apply in ascending port order so the highest enabled index lands last.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= init_val(i);
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && !is_zero_addr(wr_addr[w*ADDR_W +: ADDR_W])) begin
          r_mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read select: array lookup, optional same-cycle forwarding, then zero-register override.
  always_comb begin
    w_rd_data_p0 = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_data_p0[p*DATA_W +: DATA_W] = r_mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan means the highest matching write port is forwarded.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])) begin
          w_rd_data_p0[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
        end
      end
`endif
      // Entry 0 reads as zero even when it is being written this cycle.
      if (is_zero_addr(rd_addr[p*ADDR_W +: ADDR_W])) begin
        w_rd_data_p0[p*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // ---- stage p0 -> p1: read data and valid are captured together ----
  // Idle ports keep their last data and drop valid. Reset clears both at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rd_data_p1 <= '0;
      r_vld_p1     <= '0;
    end else begin
      r_vld_p1 <= rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          r_rd_data_p1[p*DATA_W +: DATA_W] <= w_rd_data_p0[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rd_data  = r_rd_data_p1;
  assign rd_valid = r_vld_p1;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp.
// Two instances share the same stimulus: dut_a has ZERO_REG=1 and dut_b has ZERO_REG=0.
// Both instances use two read ports and two write ports.
// Each instance is checked against its own array model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [NR-1:0]    rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NW-1:0]    wr_en = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic [NR-1:0]    rd_valid_a, rd_valid_b;

  int n_pass = 0;
  int n_total = 0;

  // Model state: k=0 models dut_a (zero register), k=1 models dut_b.
  logic [DW-1:0] m [2][DEPTH];
  logic [DW-1:0] exp_d [2][NR];
  logic          exp_v [2][NR];

  always #5 clock = ~clock;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .INIT_IDX(1)) dut_a (
    .clock(clock), .resetn(resetn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(0), .INIT_IDX(1)) dut_b (
    .clock(clock), .resetn(resetn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  function automatic logic [DW-1:0] got_d(input int k, input int p);
    return (k == 0) ? rd_data_a[p*DW +: DW] : rd_data_b[p*DW +: DW];
  endfunction

  function automatic logic got_v(input int k, input int p);
    return (k == 0) ? rd_valid_a[p] : rd_valid_b[p];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) m[k][i] = DW'(i);
      for (int p = 0; p < NR; p++) begin
        exp_d[k][p] = '0;
        exp_v[k][p] = 1'b0;
      end
    end
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int w, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[w] = en;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = '0;
  endtask

  // Compute the model's next outputs from the current inputs, update its contents,
  // then advance one clock and settle 1 ns past the edge.
  task automatic tick();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NR; p++) begin
        if (rd_en[p]) begin
          a = rd_addr[p*AW +: AW];
          v = m[k][a];
          if (BYPASS) begin
            for (int w = 0; w < NW; w++)
              if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*DW +: DW];
          end
          if (k == 0 && a == 0) v = '0;
          exp_d[k][p] = v;
          exp_v[k][p] = 1'b1;
        end else begin
          exp_v[k][p] = 1'b0;
        end
      end
      for (int w = 0; w < NW; w++) begin
        a = wr_addr[w*AW +: AW];
        if (wr_en[w] && !(k == 0 && a == 0)) m[k][a] = wr_data[w*DW +: DW];
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 0) !== 1'b0 || got_v(k, 1) !== 1'b0 || got_d(k, 0) !== '0 || got_d(k, 1) !== '0)
        $display("FAIL reset_hold k=%0d got valid=%b%b data=%h/%h required valid=00 data=0",
                 k, got_v(k, 1), got_v(k, 0), got_d(k, 1), got_d(k, 0));
      else n_pass++;
    end
    @(negedge clock);
    resetn = 1'b1;
    set_rd(0, 1'b1, 5'd7);
    set_rd(1, 1'b1, 5'd3);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 0) !== 1'b1 || got_d(k, 0) !== 32'h7 || got_v(k, 1) !== 1'b1 || got_d(k, 1) !== 32'h3)
        $display("FAIL reset_init k=%0d got %b:%h %b:%h required 1:00000007 1:00000003",
                 k, got_v(k, 0), got_d(k, 0), got_v(k, 1), got_d(k, 1));
      else n_pass++;
    end
    // Overwrite entry 7, keep reads going, then pulse reset in the middle of the cycle.
    set_wr(0, 1'b1, 5'd7, 32'h55);
    tick();
    idle();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 0) !== 1'b0 || got_v(k, 1) !== 1'b0 || got_d(k, 0) !== '0 || got_d(k, 1) !== '0)
        $display("FAIL reset_async k=%0d got valid=%b%b data=%h/%h required valid=00 data=0",
                 k, got_v(k, 1), got_v(k, 0), got_d(k, 1), got_d(k, 0));
      else n_pass++;
    end
    #1;
    resetn = 1'b1;
    set_rd(0, 1'b1, 5'd7);
    set_rd(1, 1'b1, 5'd7);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 0) !== 1'b1 || got_d(k, 0) !== 32'h7 || got_v(k, 1) !== 1'b1 || got_d(k, 1) !== 32'h7)
        $display("FAIL reset_restore k=%0d got %b:%h %b:%h required 1:00000007 on both",
                 k, got_v(k, 0), got_d(k, 0), got_v(k, 1), got_d(k, 1));
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_write_read();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd5);
    tick();
    for (int k = 0; k < 2; k++) for (int p = 0; p < NR; p++) begin
      n_total++;
      if (got_v(k, p) !== 1'b1 || got_d(k, p) !== 32'hDEADBEEF)
        $display("FAIL write_read k=%0d p=%0d got %b:%h required 1:deadbeef", k, p, got_v(k, p), got_d(k, p));
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] req;
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      req = (k == 0) ? 32'h0 : 32'hFFFFFFFF;
      n_total++;
      if (got_v(k, 0) !== 1'b1 || got_d(k, 0) !== req)
        $display("FAIL zero_reg k=%0d got %b:%h required 1:%h", k, got_v(k, 0), got_d(k, 0), req);
      else n_pass++;
    end
    // Same-cycle write and read of entry 0.
    set_wr(1, 1'b1, 5'd0, 32'h123);
    set_rd(1, 1'b1, 5'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      req = (k == 0) ? 32'h0 : (BYPASS ? 32'h123 : 32'hFFFFFFFF);
      n_total++;
      if (got_v(k, 1) !== 1'b1 || got_d(k, 1) !== req)
        $display("FAIL zero_reg_raw k=%0d got %b:%h required 1:%h", k, got_v(k, 1), got_d(k, 1), req);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_collision();
    set_wr(0, 1'b1, 5'd9, 32'h11);
    set_wr(1, 1'b1, 5'd9, 32'h22);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd9);
    set_rd(1, 1'b1, 5'd9);
    tick();
    for (int k = 0; k < 2; k++) for (int p = 0; p < NR; p++) begin
      n_total++;
      if (got_v(k, p) !== 1'b1 || got_d(k, p) !== 32'h22)
        $display("FAIL collision k=%0d p=%0d got %b:%h required 1:00000022", k, p, got_v(k, p), got_d(k, p));
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_raw();
    logic [DW-1:0] req;
    set_wr(0, 1'b1, 5'd3, 32'hA);
    tick();
    set_wr(0, 1'b1, 5'd3, 32'hB);
    set_rd(0, 1'b1, 5'd3);
    tick();
    idle();
    req = BYPASS ? 32'hB : 32'hA;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 0) !== 1'b1 || got_d(k, 0) !== req)
        $display("FAIL raw_same_cycle k=%0d got %b:%h required 1:%h", k, got_v(k, 0), got_d(k, 0), req);
      else n_pass++;
    end
    set_rd(0, 1'b1, 5'd3);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 0) !== 1'b1 || got_d(k, 0) !== 32'hB)
        $display("FAIL raw_next_cycle k=%0d got %b:%h required 1:0000000b", k, got_v(k, 0), got_d(k, 0));
      else n_pass++;
    end
    // Colliding writes forwarded to a same-cycle read: the higher-index port must win.
    set_wr(0, 1'b1, 5'd12, 32'h11);
    set_wr(1, 1'b1, 5'd12, 32'h22);
    set_rd(1, 1'b1, 5'd12);
    tick();
    idle();
    req = BYPASS ? 32'h22 : 32'hC;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 1) !== 1'b1 || got_d(k, 1) !== req)
        $display("FAIL raw_collision k=%0d got %b:%h required 1:%h", k, got_v(k, 1), got_d(k, 1), req);
      else n_pass++;
    end
  endtask

  task automatic test_idle_port();
    set_wr(0, 1'b1, 5'd4, 32'h4);
    tick();
    idle();
    set_rd(1, 1'b1, 5'd4);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got_v(k, 1) !== 1'b1 || got_d(k, 1) !== 32'h4)
        $display("FAIL idle_first_read k=%0d got %b:%h required 1:00000004", k, got_v(k, 1), got_d(k, 1));
      else n_pass++;
    end
    for (int c = 0; c < 3; c++) begin
      idle();
      set_rd(1, 1'b0, 5'($urandom_range(0, 31)));
      set_rd(0, 1'b1, 5'($urandom_range(0, 31)));
      if (c == 0) set_wr(1, 1'b1, 5'd4, 32'h99);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (got_v(k, 1) !== 1'b0 || got_d(k, 1) !== 32'h4)
          $display("FAIL idle_hold c=%0d k=%0d got %b:%h required 0:00000004", c, k, got_v(k, 1), got_d(k, 1));
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NR; p++)
        set_rd(p, 1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)));
      for (int w = 0; w < NW; w++)
        set_wr(w, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
               $urandom);
      tick();
      for (int k = 0; k < 2; k++) for (int p = 0; p < NR; p++) begin
        n_total++;
        if (got_v(k, p) !== exp_v[k][p] || got_d(k, p) !== exp_d[k][p])
          $display("FAIL random c=%0d k=%0d p=%0d got %b:%h required %b:%h",
                   c, k, p, got_v(k, p), got_d(k, p), exp_v[k][p], exp_d[k][p]);
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_collision();
    test_raw();
    test_idle_port();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
